write_flash_page: RTL and testbench

- Page-program function module for the SPI flash controller. It is the write-direction counterpart of the burst-read module.
- On a start pulse it issues a one-byte WRITE ENABLE request to the SPI request engine.
- It then issues a PAGE PROGRAM request: command byte, 3 address bytes MSB first, then PAGE_LEN data bytes pulled from an upstream valid/ready stream.
- It sits between the frame/page scheduler and the shared SPI request engine. Status polling is done by a separate module.

---
 rtl/write_flash_page.sv | 193 +++++++++++++++++++
 tb/tb_write_flash_page.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_flash_page.sv
// Page-program sequencer: issues WRITE ENABLE, then PAGE PROGRAM (cmd, 3 address
// bytes, PAGE_LEN streamed data bytes) to the shared SPI request engine.
module write_flash_page #(
  parameter int unsigned SSIZE       = 1,
  parameter int unsigned DSIZE       = 8,
  parameter int unsigned PAGE_LEN    = 256,
  parameter logic [7:0]  WREN_CMD    = 8'h06,
  parameter logic [7:0]  PROG_CMD_X1 = 8'h02,
  parameter logic [7:0]  PROG_CMD_X4 = 8'h32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      page_addr,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  output logic             in_ready,
  output logic             req,
  input  logic             req_busy,
  output logic [23:0]      req_len,
  output logic [23:0]      req_wr_len,
  output logic [2:0]       req_cmd,
  input  logic             clk_en,
  output logic             wr_vld,
  input  logic             wr_ready,
  output logic [DSIZE-1:0] wr_data,
  input  logic             rd_vld,
  input  logic [DSIZE-1:0] rd_data,
  output logic             rd_ready
);

  localparam logic [23:0] WREN_LEN = 24'(8 / SSIZE);
  localparam logic [23:0] PP_LEN   = 24'((PAGE_LEN + 4) * 8 / SSIZE);
  localparam logic [8:0]  LAST_IDX = 9'(PAGE_LEN - 1);
  localparam logic [7:0]  PROG_CMD = (SSIZE == 1) ? PROG_CMD_X1 : PROG_CMD_X4;

  typedef enum logic [2:0] {
    IDLE, WREN_REQ, WREN_EXEC, PP_REQ, PP_EXEC, FSH
  } req_state_e;

  typedef enum logic [2:0] {
    DIDLE, SEND_WREN, SEND_CMD, ADDR2, ADDR1, ADDR0, SEND_DATA, WAIT_END
  } dat_state_e;

  req_state_e       rs_q;
  dat_state_e       ds_q;
  logic [23:0]      addr_q;
  logic [DSIZE-1:0] byte_q;
  logic             vld_q;
  logic [8:0]       cnt_q;
  logic             req_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [23:0]      len_q;
  logic [2:0]       cmd_q;

  logic data_phase;
  logic strobe;
  logic xfer;
  logic unused_rd;

  // Data bytes bypass the byte register so the stream adds no latency.
  assign data_phase = (ds_q == SEND_DATA);
  assign strobe     = wr_ready && clk_en;
  assign wr_vld     = data_phase ? in_valid : vld_q;
  assign wr_data    = data_phase ? in_data  : byte_q;
  assign in_ready   = data_phase && strobe;
  assign xfer       = wr_vld && strobe;

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign req        = req_q;
  assign req_len    = len_q;
  assign req_wr_len = len_q;
  assign req_cmd    = cmd_q;
  assign rd_ready   = 1'b1;
  assign unused_rd  = ^{rd_vld, rd_data};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rs_q   <= IDLE;
      ds_q   <= DIDLE;
      addr_q <= '0;
      byte_q <= '0;
      vld_q  <= 1'b0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      len_q  <= '0;
      cmd_q  <= '0;
    end else begin
      done_q <= 1'b0;

      case (ds_q)
        SEND_WREN: if (xfer) begin
          ds_q  <= WAIT_END;
          vld_q <= 1'b0;
        end
        SEND_CMD: if (xfer) begin
          ds_q   <= ADDR2;
          byte_q <= DSIZE'(addr_q[23:16]);
        end
        ADDR2: if (xfer) begin
          ds_q   <= ADDR1;
          byte_q <= DSIZE'(addr_q[15:8]);
        end
        ADDR1: if (xfer) begin
          ds_q   <= ADDR0;
          byte_q <= DSIZE'(addr_q[7:0]);
        end
        ADDR0: if (xfer) begin
          ds_q  <= SEND_DATA;
          vld_q <= 1'b0;
        end
        SEND_DATA: begin
          if (strobe && !in_valid) err_q <= 1'b1;
          if (xfer) begin
            cnt_q <= cnt_q + 9'd1;
            if (cnt_q == LAST_IDX) ds_q <= WAIT_END;
          end
        end
        default: ;
      endcase

      // Request FSM is evaluated last so an abort overrides any data-FSM step.
      case (rs_q)
        IDLE: if (start) begin
          rs_q   <= WREN_REQ;
          busy_q <= 1'b1;
          err_q  <= 1'b0;
          addr_q <= page_addr;
          len_q  <= WREN_LEN;
          cmd_q  <= 3'b001;
        end
        WREN_REQ: begin
          if (req_busy) begin
            req_q  <= 1'b0;
            rs_q   <= WREN_EXEC;
            ds_q   <= SEND_WREN;
            byte_q <= DSIZE'(WREN_CMD);
            vld_q  <= 1'b1;
          end else begin
            req_q <= 1'b1;
          end
        end
        WREN_EXEC: if (!req_busy) begin
          if (ds_q == WAIT_END) begin
            rs_q  <= PP_REQ;
            len_q <= PP_LEN;
          end else begin
            err_q  <= 1'b1;
            rs_q   <= FSH;
            done_q <= 1'b1;
          end
          ds_q  <= DIDLE;
          vld_q <= 1'b0;
        end
        PP_REQ: begin
          if (req_busy) begin
            req_q  <= 1'b0;
            rs_q   <= PP_EXEC;
            ds_q   <= SEND_CMD;
            byte_q <= DSIZE'(PROG_CMD);
            vld_q  <= 1'b1;
            cnt_q  <= '0;
          end else begin
            req_q <= 1'b1;
          end
        end
        PP_EXEC: if (!req_busy) begin
          if (ds_q != WAIT_END) err_q <= 1'b1;
          rs_q   <= FSH;
          done_q <= 1'b1;
          ds_q   <= DIDLE;
          vld_q  <= 1'b0;
        end
        FSH: begin
          rs_q   <= IDLE;
          busy_q <= 1'b0;
        end
        default: rs_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_flash_page.sv
// Directed bench for write_flash_page: a behavioural SPI engine and upstream
// source drive an x1 (PAGE_LEN=256) and a quad (PAGE_LEN=16) instance.
module tb_write_flash_page;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel   = 1'b0;
  logic        start = 1'b0;
  logic [23:0] page_addr = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        req_busy = 1'b0;
  logic        clk_en = 1'b0;
  logic        wr_ready = 1'b0;
  logic        rd_vld = 1'b0;
  logic [7:0]  rd_data = '0;

  logic busy1, done1, error1, in_ready1, req1, wr_vld1, rd_ready1;
  logic busy4, done4, error4, in_ready4, req4, wr_vld4, rd_ready4;
  logic [23:0] req_len1, req_wr_len1, req_len4, req_wr_len4;
  logic [2:0]  req_cmd1, req_cmd4;
  logic [7:0]  wr_data1, wr_data4;

  logic busy, done, error, in_ready, req, wr_vld, rd_ready;
  logic [23:0] req_len, req_wr_len;
  logic [2:0]  req_cmd;
  logic [7:0]  wr_data;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  write_flash_page #(.SSIZE(1), .PAGE_LEN(256)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start && !sel), .page_addr(page_addr),
    .busy(busy1), .done(done1), .error(error1),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .req(req1), .req_busy(req_busy), .req_len(req_len1), .req_wr_len(req_wr_len1),
    .req_cmd(req_cmd1), .clk_en(clk_en), .wr_vld(wr_vld1), .wr_ready(wr_ready),
    .wr_data(wr_data1), .rd_vld(rd_vld), .rd_data(rd_data), .rd_ready(rd_ready1)
  );

  write_flash_page #(.SSIZE(4), .PAGE_LEN(16)) dut4 (
    .clock(clock), .rst_n(rst_n), .start(start && sel), .page_addr(page_addr),
    .busy(busy4), .done(done4), .error(error4),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .req(req4), .req_busy(req_busy), .req_len(req_len4), .req_wr_len(req_wr_len4),
    .req_cmd(req_cmd4), .clk_en(clk_en), .wr_vld(wr_vld4), .wr_ready(wr_ready),
    .wr_data(wr_data4), .rd_vld(rd_vld), .rd_data(rd_data), .rd_ready(rd_ready4)
  );

  assign busy       = sel ? busy4       : busy1;
  assign done       = sel ? done4       : done1;
  assign error      = sel ? error4      : error1;
  assign in_ready   = sel ? in_ready4   : in_ready1;
  assign req        = sel ? req4        : req1;
  assign wr_vld     = sel ? wr_vld4     : wr_vld1;
  assign rd_ready   = sel ? rd_ready4   : rd_ready1;
  assign req_len    = sel ? req_len4    : req_len1;
  assign req_wr_len = sel ? req_wr_len4 : req_wr_len1;
  assign req_cmd    = sel ? req_cmd4    : req_cmd1;
  assign wr_data    = sel ? wr_data4    : wr_data1;

  typedef struct {
    bit          quad;
    logic [23:0] addr;
    int unsigned ce_period;
    bit          rdy_toggle;
    int unsigned gap_at;
    int unsigned gap_len;
    int unsigned abort_at;
    bit          start_mid;
    int unsigned rst_at;
    logic        exp_err;
    int unsigned exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int unsigned i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic logic [7:0] exp_byte(input bit quad, input logic [23:0] a,
                                          input int unsigned ph, input int unsigned idx);
    if (ph == 1) return 8'h06;
    case (idx)
      0: return quad ? 8'h32 : 8'h02;
      1: return a[23:16];
      2: return a[15:8];
      3: return a[7:0];
      default: return pat(idx - 4);
    endcase
  endfunction

  task automatic run_seq(input vec_t v);
    int unsigned ph = 0, cnt = 0, exp_cnt = 0, consumed = 0, ir_cnt = 0;
    int unsigned gap_rem, bad = 0, first_bad = 0, done_cnt = 0;
    bit eng = 0, fin = 0;
    logic err_at_done = 1'b0;
    logic [7:0] eb;
    gap_rem = v.gap_len;
    sel = v.quad;
    @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 0);
    start = 1'b1;
    page_addr = v.addr;
    @(negedge clock);
    start = 1'b0;
    page_addr = ~v.addr;
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("error_cleared", {31'd0, error}, 0);
    for (int unsigned cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (v.rst_at != 0 && consumed == v.rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_req", {31'd0, req}, 0);
        chk("rst_req_len", {8'd0, req_len}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_wr_vld", {31'd0, wr_vld}, 0);
        chk("rst_rd_ready", {31'd0, rd_ready}, 1);
        req_busy = 1'b0;
        clk_en = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_no_done", {31'd0, done}, 0);
        rst_n = 1'b1;
        return;
      end
      start = 1'b0;
      if (v.start_mid && cyc == 3) begin
        start = 1'b1;
        page_addr = 24'hFFFFFF;
      end
      if (done) begin
        done_cnt++;
        fin = 1;
        err_at_done = error;
        if (v.start_mid) start = 1'b1;
      end
      if (!eng && req) begin
        chk("req_len", {8'd0, req_len}, (ph == 0) ? (v.quad ? 2 : 8) : (v.quad ? 40 : 2080));
        chk("req_wr_len", {8'd0, req_wr_len}, (ph == 0) ? (v.quad ? 2 : 8) : (v.quad ? 40 : 2080));
        chk("req_cmd", {29'd0, req_cmd}, 1);
        req_busy = 1'b1;
        eng = 1;
        cnt = 0;
        exp_cnt = (ph == 0) ? 1 : (v.quad ? 20 : 260);
        ph++;
        clk_en = 1'b0;
      end else if (eng && (cnt == exp_cnt || (ph == 2 && v.abort_at != 0 && cnt == 4 + v.abort_at))) begin
        req_busy = 1'b0;
        eng = 0;
        clk_en = 1'b0;
      end else begin
        clk_en = eng && (cyc % v.ce_period == 0);
        wr_ready = v.rdy_toggle ? (cyc % 3 != 0) : 1'b1;
      end
      in_valid = !(gap_rem != 0 && consumed == v.gap_at);
      in_data = pat(consumed);
      #1;
      if (eng && wr_vld && wr_ready && clk_en) begin
        eb = exp_byte(v.quad, v.addr, ph, cnt);
        if (wr_data !== eb) begin
          if (bad == 0) first_bad = ph * 1000 + cnt;
          bad++;
        end
        cnt++;
      end
      if (in_ready) begin
        ir_cnt++;
        if (in_valid) consumed++;
        else if (gap_rem > 0) gap_rem--;
      end
      if (!fin) @(negedge clock);
    end
    chk("done_pulses", done_cnt, 1);
    chk("error_at_done", {31'd0, err_at_done}, {31'd0, v.exp_err});
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_done", {31'd0, busy}, 0);
    chk("done_single", {31'd0, done}, 0);
    chk("error_sticky", {31'd0, error}, {31'd0, v.exp_err});
    @(negedge clock);
    chk("still_idle", {31'd0, busy}, 0);
    chk("phases", ph, 2);
    chk("data_consumed", consumed, v.exp_data);
    chk("in_ready_cycles", ir_cnt, v.exp_data + v.gap_len);
    chk("pp_bytes", cnt, v.exp_data + 4);
    if (bad != 0) chk("byte_stream_first_bad_ph_idx", first_bad, 32'hFFFF_FFFF);
    else chk("byte_stream_errors", bad, 0);
  endtask

  vec_t vecs[10];

  initial begin
    //           quad addr          ce tog gap_at len abort mid rst err data
    vecs[0] = '{1'b0, 24'h012300, 1, 1'b0, 0,  0, 0, 1'b0, 0,  1'b0, 256};
    vecs[1] = '{1'b1, 24'hABCDEF, 1, 1'b0, 0,  0, 0, 1'b0, 0,  1'b0, 16};
    vecs[2] = '{1'b1, 24'h00FF10, 4, 1'b1, 0,  0, 0, 1'b0, 0,  1'b0, 16};
    vecs[3] = '{1'b0, 24'h456789, 4, 1'b1, 0,  0, 0, 1'b0, 0,  1'b0, 256};
    vecs[4] = '{1'b0, 24'h100000, 1, 1'b0, 10, 3, 0, 1'b0, 0,  1'b1, 256};
    vecs[5] = '{1'b0, 24'h0000FF, 1, 1'b0, 0,  0, 0, 1'b0, 0,  1'b0, 256};
    vecs[6] = '{1'b0, 24'h200100, 1, 1'b0, 0,  0, 5, 1'b1, 0,  1'b1, 5};
    vecs[7] = '{1'b0, 24'h030303, 1, 1'b0, 0,  0, 0, 1'b0, 20, 1'b0, 0};
    vecs[8] = '{1'b0, 24'h7F8000, 2, 1'b0, 0,  0, 0, 1'b0, 0,  1'b0, 256};
    vecs[9] = '{1'b1, 24'h123456, 1, 1'b0, 3,  2, 0, 1'b0, 0,  1'b1, 16};

    @(negedge clock);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_error", {31'd0, error}, 0);
    chk("reset_req", {31'd0, req}, 0);
    chk("reset_req_len", {8'd0, req_len}, 0);
    chk("reset_req_wr_len", {8'd0, req_wr_len}, 0);
    chk("reset_req_cmd", {29'd0, req_cmd}, 0);
    chk("reset_wr_vld", {31'd0, wr_vld}, 0);
    chk("reset_wr_data", {24'd0, wr_data}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 0);
    chk("reset_rd_ready", {31'd0, rd_ready}, 1);
    rst_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_seq(vecs[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
